// File: rtl/iter_mul_seq.sv
// rtl/iter_mul_seq.sv - iterative shift-and-add unsigned multiplier with START/BUSY/DONE sequencing
module iter_mul_seq #(
    parameter int WIDTH = 24
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [2*WIDTH-1:0]     P
);

    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [SW-1:0]    step;
    logic [WIDTH:0]   sum;

    // hi never exceeds 2^WIDTH-1 between steps, so a WIDTH+1 bit sum cannot overflow
    always_comb begin
        sum = hi + (lo[0] ? {1'b0, mcand} : '0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            P     <= '0;
            step  <= '0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    DONE <= 1'b0;
                    if (START) begin
                        mcand <= A;
                        hi    <= '0;
                        lo    <= B;
                        step  <= '0;
                        BUSY  <= 1'b1;
                        state <= RUN;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    hi   <= {1'b0, sum[WIDTH:1]};
                    lo   <= {sum[0], lo[WIDTH-1:1]};
                    step <= step + 1'b1;
                    if (step == LAST) begin
                        P     <= {sum, lo[WIDTH-1:1]};
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/iter_mul_seq.md
# iter_mul_seq

Iterative shift-and-add unsigned multiplier with its own sequencing controller. It computes one WIDTH×WIDTH mantissa product over WIDTH clock cycles using a single WIDTH-bit adder. It sits between the FPU multiplier's operand-unpack stage and the normalise/round stage. It uses a START/BUSY/DONE handshake so upstream logic can issue operations back-to-back.

## Interface
- WIDTH, 24: operand width in bits (24 = single-precision mantissa with hidden bit); legal range 2..32.
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request to begin a multiply; sampled only when BUSY=0.
- A  input  WIDTH  multiplicand, unsigned; sampled with an accepted START.
- B  input  WIDTH  multiplier, unsigned; sampled with an accepted START.
- BUSY  output  1  high while a multiply is in progress; START is ignored while high.
- DONE  output  1  one-cycle pulse marking that P holds a new result.
- P  output  2*WIDTH  product A*B, registered; holds the last result until the next DONE.

## Operation
- FSM states are IDLE, RUN and FIN. RESET forces IDLE from any state.
- IDLE: BUSY=0, DONE=0. On START=1:
  - mcand←A, hi←0 (WIDTH+1 bits including carry), lo←B, step←0.
  - Next state is RUN.
- RUN: BUSY=1. Each cycle performs one step:
  - sum = hi[WIDTH-1:0] + (lo[0] ? mcand : 0), computed at WIDTH+1 bits.
  - {hi,lo} ← {sum,lo} >> 1, a logical right shift of the full 2*WIDTH+1 bit vector. lo behaves as an LSB-first shift register.
  - step←step+1. step is a counter of $clog2(WIDTH) bits.
  - On the step where step==WIDTH-1, P is loaded with the shifted {hi[WIDTH-1:0],lo} and the next state is FIN.
- FIN: BUSY=0, DONE=1 for exactly this one cycle.
  - START=1 in FIN is accepted exactly as in IDLE (operands loaded, next state RUN). This gives back-to-back issue.
  - With START=0, next state is IDLE.
- START in RUN is ignored and not queued. A and B are don't-care except in the accepting cycle.
- The arithmetic is exact: hi never exceeds WIDTH+1 bits, so the product never overflows 2*WIDTH bits. (2^W-1)^2 < 2^(2W).
- There are no data-dependent shortcuts. Latency is independent of operand values, including zero operands.
- Reset values: state=IDLE, BUSY=0, DONE=0, P=0, step=0, hi/lo/mcand=0.

## Timing
- Edge E0 samples an accepted START. BUSY is high from E0 through edge E(WIDTH).
- Steps execute at edges E1..E(WIDTH).
- DONE is high and the new P is visible in the cycle after E(WIDTH). Latency is WIDTH+1 cycles from the START cycle to the DONE cycle.
- Throughput is one result per WIDTH+1 cycles with START held or re-asserted in FIN.
- P changes only on the edge that enters FIN. It is stable during RUN, and previous results remain readable.
- RESET asserted mid-RUN aborts at the next edge:
  - no DONE is produced and P=0;
  - a START coincident with RESET is ignored.

## Test plan
- Basic multiply, WIDTH=24: A=3, B=5, START for one cycle -> BUSY for 24 cycles, DONE pulse in cycle 25 after START, P=15.
- Maximum operands: A=B=0xFFFFFF -> P=0xFFFFFE000001.
- Zero operand: A=0, B=0xABCDEF -> DONE still at the 25-cycle latency, P=0.
- Ignored START: START pulsed with new operands (A=7, B=9) at cycles 5 and 20 of a running 3×5 -> P=15 with a single DONE, and the FSM returns to IDLE.
- Back-to-back issue: START held high with 3×5, then 0x800000×2 presented during the FIN cycle -> P=15 for the first DONE and P=0x1000000 for the second, 25 cycles later; no idle gap.
- Reset mid-operation: RESET at cycle 10 of a multiply -> BUSY=0, DONE=0, P=0 next cycle. A following 6×7 then yields P=42 with nominal latency.
